// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the instruction sequencer: instruction width,
// instruction word type and sequencer FSM states.
package cpu_pkg;

    localparam int IW = 19;

    typedef logic [IW-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Load/control/issue bundle between the instruction sequencer and its
// neighbours; master drives loads and control, slave is the sequencer.
interface instr_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int IW    = cpu_pkg::IW
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_instr;
    logic          start;
    logic          halt;
    logic          clear;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    modport master (
        output load_valid, load_instr, start, halt, clear,
        input  load_ready, instruction, instr_valid, pc, count, busy, done
    );

    modport slave (
        input  load_valid, load_instr, start, halt, clear,
        output load_ready, instruction, instr_valid, pc, count, busy, done
    );

endinterface

// File: rtl/instr_sequencer_store.sv
// Program store: DEPTH x IW register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module instr_store #(
    parameter  int DEPTH = 16,
    parameter  int IW    = cpu_pkg::IW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a small program, then issues it one word per
// clock to the CPU. Define INSTR_SEQ_LOOP_EN to repeat the program until halt.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = cpu_pkg::IW
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    seq_state_t    state_q;
    logic [CW-1:0] pc_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] instr_q;
    logic          vld_q;

    logic          load_ready;
    logic          load_fire;
    logic          more;
    logic          launch;
    logic [AW-1:0] raddr;
    logic [IW-1:0] rdata;

    // pc is one bit wider than an address so pc==count==DEPTH is representable.
    assign more       = (pc_q < count_q);
    assign load_ready = (state_q == IDLE) && (count_q < DEPTH_C) && !bus.start && !bus.clear;
    assign load_fire  = bus.load_valid && load_ready;
    assign launch     = bus.start && (count_q != '0);

    // Outside an in-range RUN fetch the read port points at slot 0, which
    // serves both the first issue after start and the loop wrap.
    assign raddr = (state_q == RUN && more) ? pc_q[AW-1:0] : '0;

    instr_store #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_store (
        .clk     (clk),
        .we_i    (load_fire),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.load_instr),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                    end else if (launch) begin
                        state_q <= RUN;
                        instr_q <= rdata;
                        vld_q   <= 1'b1;
                        pc_q    <= ONE_C;
                    end else if (load_fire) begin
                        count_q <= count_q + ONE_C;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        vld_q   <= 1'b0;
                        pc_q    <= '0;
                        state_q <= IDLE;
                    end else if (more) begin
                        instr_q <= rdata;
                        pc_q    <= pc_q + ONE_C;
                    end else begin
`ifdef INSTR_SEQ_LOOP_EN
                        instr_q <= rdata;
                        pc_q    <= ONE_C;
`else
                        vld_q   <= 1'b0;
                        pc_q    <= '0;
                        state_q <= DONE;
`endif
                    end
                end
                DONE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (launch) begin
                        state_q <= RUN;
                        instr_q <= rdata;
                        vld_q   <= 1'b1;
                        pc_q    <= ONE_C;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    pc_q    <= '0;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = vld_q;
    assign bus.pc          = pc_q[AW-1:0];
    assign bus.count       = count_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: program-level reference model checked every
// cycle, directed scenarios with literal expectations, then random control.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int IW    = 19;
`ifdef INSTR_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

    instr_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the program as an array, plus "next slot to issue".
    typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t          ph      = M_IDLE;
    int            cnt     = 0;
    int            nxt     = 0;
    logic [IW-1:0] prog [DEPTH];
    logic [IW-1:0] m_instr = '0;
    bit            m_valid = 1'b0;

    task automatic m_launch();
        ph      = M_RUN;
        m_instr = prog[0];
        m_valid = 1'b1;
        nxt     = 1;
    endtask

    task automatic m_step(input bit lv, input logic [IW-1:0] li, input bit st, input bit hl, input bit cl);
        bit rdy;
        rdy = (ph == M_IDLE) && (cnt < DEPTH) && !st && !cl;
        case (ph)
            M_IDLE: begin
                if (cl) cnt = 0;
                else if (st && cnt > 0) m_launch();
                else if (lv && rdy) begin
                    prog[cnt] = li;
                    cnt++;
                end
            end
            M_RUN: begin
                if (hl) begin
                    m_valid = 1'b0; nxt = 0; ph = M_IDLE;
                end else if (nxt < cnt) begin
                    m_instr = prog[nxt]; nxt++;
                end else if (LOOP) begin
                    m_instr = prog[0]; nxt = 1;
                end else begin
                    m_valid = 1'b0; nxt = 0; ph = M_DONE;
                end
            end
            default: begin
                if (cl) begin
                    cnt = 0; ph = M_IDLE;
                end else if (st && cnt > 0) m_launch();
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = M_IDLE; cnt = 0; nxt = 0; m_instr = '0; m_valid = 1'b0;
            end else begin
                m_step(bus.load_valid, bus.load_instr, bus.start, bus.halt, bus.clear);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", bus.instr_valid, m_valid);
            chk("instr", bus.instruction, m_instr);
            chk("pc",    bus.pc, nxt % DEPTH);
            chk("count", bus.count, cnt);
            chk("busy",  bus.busy, ph == M_RUN);
            chk("done",  bus.done, ph == M_DONE);
            chk("ready", bus.load_ready,
                (ph == M_IDLE) && (cnt < DEPTH) && !bus.start && !bus.clear);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [IW-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_instr = d;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic to_idle_empty();
        bus.halt = 1'b1;
        tick();
        bus.halt  = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    logic [IW-1:0] data [17];

    initial begin
        bus.load_valid = 1'b0;
        bus.load_instr = '0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.clear      = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_pc",    bus.pc, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_instr", bus.instruction, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start with an empty program is ignored.
        pulse_start();
        chk("empty_busy",  bus.busy, 0);
        chk("empty_valid", bus.instr_valid, 0);
        tick();
        chk("empty_busy2", bus.busy, 0);

        // Three-instruction program.
        load(19'h00001);
        load(19'h12345);
        load(19'h7FFFF);
        chk("t1_count", bus.count, 3);
        pulse_start();
        chk("t1_v0", bus.instr_valid, 1);
        chk("t1_i0", bus.instruction, 19'h00001);
        tick();
        chk("t1_i1", bus.instruction, 19'h12345);
        tick();
        chk("t1_i2", bus.instruction, 19'h7FFFF);
        chk("t1_v2", bus.instr_valid, 1);
        tick();
`ifdef INSTR_SEQ_LOOP_EN
        chk("t1_wrap_i", bus.instruction, 19'h00001);
        chk("t1_wrap_v", bus.instr_valid, 1);
        chk("t1_wrap_pc", bus.pc, 1);
`else
        chk("t1_end_v",  bus.instr_valid, 0);
        chk("t1_done",   bus.done, 1);
        chk("t1_pc",     bus.pc, 0);
        chk("t1_hold_i", bus.instruction, 19'h7FFFF);
        // start and clear together in DONE: clear wins.
        bus.start = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        chk("sc_busy",  bus.busy, 0);
        chk("sc_done",  bus.done, 0);
        chk("sc_count", bus.count, 0);
        chk("sc_valid", bus.instr_valid, 0);
`endif
        to_idle_empty();

        // Overfill: 17 loads into a 16-slot store.
        for (int i = 0; i < 17; i++) data[i] = IW'($urandom);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.load_instr = data[i];
            tick();
        end
        chk("full_ready", bus.load_ready, 0);
        chk("full_count", bus.count, 16);
        bus.load_instr = data[16];
        tick();
        bus.load_valid = 1'b0;
        chk("full_count2", bus.count, 16);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            chk("full_issue", bus.instruction, data[i]);
            chk("full_issue_v", bus.instr_valid, 1);
            if (i < 15) tick();
        end
        tick();
`ifndef INSTR_SEQ_LOOP_EN
        chk("full_done", bus.done, 1);
        chk("full_end_v", bus.instr_valid, 0);
`endif
        to_idle_empty();

        // Halt on the second issued cycle.
        for (int i = 0; i < 5; i++) begin
            data[i] = IW'($urandom);
            load(data[i]);
        end
        pulse_start();
        chk("h_i0", bus.instruction, data[0]);
        tick();
        chk("h_i1", bus.instruction, data[1]);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("h_valid", bus.instr_valid, 0);
        chk("h_busy",  bus.busy, 0);
        chk("h_pc",    bus.pc, 0);
        chk("h_count", bus.count, 5);
        pulse_start();
        chk("h_re_i0", bus.instruction, data[0]);
        chk("h_re_v",  bus.instr_valid, 1);
        to_idle_empty();

`ifdef INSTR_SEQ_LOOP_EN
        // Looping two-instruction program with no bubble.
        load(19'h0AAAA);
        load(19'h05555);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk("loop_v", bus.instr_valid, 1);
            chk("loop_i", bus.instruction, (i % 2 == 0) ? 19'h0AAAA : 19'h05555);
            tick();
        end
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("loop_halt_v", bus.instr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("loop_no_done", bus.done, 0);
        end
        to_idle_empty();
`endif

        // Randomised control and load traffic.
        for (int n = 0; n < 400; n++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_instr = IW'($urandom);
            bus.start      = ($urandom_range(0, 19) == 0);
            bus.halt       = ($urandom_range(0, 29) == 0);
            bus.clear      = ($urandom_range(0, 59) == 0);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.clear      = 1'b0;
        to_idle_empty();

        // Asynchronous reset between edges while running.
        for (int i = 0; i < 4; i++) load(IW'($urandom));
        pulse_start();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.instr_valid, 0);
        chk("ar_busy",  bus.busy, 0);
        chk("ar_done",  bus.done, 0);
        chk("ar_pc",    bus.pc, 0);
        chk("ar_count", bus.count, 0);
        chk("ar_instr", bus.instruction, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
